// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with shadow/active digit registers.
// Shadow writes reach the display only through a commit applied at a frame wrap.
module seg_scan_ctrl #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    input  logic [3:0] blank_mask,
    output logic       commit_pending,
    output logic       frame_done,
    output logic [3:0] dig_en,
    output logic       led_a,
    output logic       led_b,
    output logic       led_c,
    output logic       led_d,
    output logic       led_e,
    output logic       led_f,
    output logic       led_g
);

    localparam int unsigned MAXC      = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CW        = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned SHOW_LAST = DIV - 1;
    localparam int unsigned GAP_LAST  = (BLANK > 0) ? BLANK - 1 : 0;

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_idx;
    logic [1:0]      w_idx_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_advance;
    logic            w_wrap;
    logic [3:0][3:0] r_shadow;
    logic [3:0][3:0] r_active;
    logic            r_pending;
    logic            r_frame_done;
    logic [6:0]      w_seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    seg_decode = 7'b1111110;
            4'h1:    seg_decode = 7'b0110000;
            4'h2:    seg_decode = 7'b1101101;
            4'h3:    seg_decode = 7'b1111001;
            4'h4:    seg_decode = 7'b0110011;
            4'h5:    seg_decode = 7'b1011011;
            4'h6:    seg_decode = 7'b1011111;
            4'h7:    seg_decode = 7'b1110000;
            4'h8:    seg_decode = 7'b1111111;
            4'h9:    seg_decode = 7'b1111011;
            4'hA:    seg_decode = 7'b1110111;
            4'hB:    seg_decode = 7'b0011111;
            4'hC:    seg_decode = 7'b1001110;
            4'hD:    seg_decode = 7'b0111101;
            4'hE:    seg_decode = 7'b1001111;
            default: seg_decode = 7'b1000111;
        endcase
    endfunction

    // State register: scan state, digit index and dwell counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_SHOW;
            r_idx   <= 2'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; with no blank time the scan stays in SHOW and just steps idx
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_advance   = 1'b0;
        if (r_state == ST_SHOW) begin
            if (r_cnt == CW'(SHOW_LAST)) begin
                w_cnt_nxt = '0;
                if (BLANK == 0) begin
                    w_advance = 1'b1;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
        end else begin
            if (r_cnt == CW'(GAP_LAST)) begin
                w_cnt_nxt   = '0;
                w_advance   = 1'b1;
                w_state_nxt = ST_SHOW;
            end
        end
        if (w_advance) begin
            w_idx_nxt = r_idx + 2'd1;
        end
        w_wrap = w_advance && (r_idx == 2'd3);
    end

    // Output logic: blank_mask acts live on the displayed digit only
    always_comb begin
        dig_en = 4'b0000;
        w_seg  = 7'b0000000;
        if ((r_state == ST_SHOW) && !blank_mask[r_idx]) begin
            dig_en = 4'b0001 << r_idx;
            w_seg  = seg_decode(r_active[r_idx]);
        end
    end

    assign {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = w_seg;

    // Digit storage and commit handshake; the copy sees pre-edge shadow contents
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (wr_en) begin
                r_shadow[wr_addr] <= wr_data;
            end
            if (w_wrap && (r_pending || commit)) begin
                r_active  <= r_shadow;
                r_pending <= 1'b0;
            end else if (commit) begin
                r_pending <= 1'b1;
            end
            r_frame_done <= w_wrap;
        end
    end

    assign commit_pending = r_pending;
    assign frame_done     = r_frame_done;

endmodule
